// File: rtl/rom_dl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rom_dl_pkg
//  Brief    : Shared types and default region map for the ROM download path.
//  Revision : 1.0  initial release
// ============================================================================
package rom_dl_pkg;

    localparam int          c_AW       = 17;
    localparam logic [16:0] c_R0_END   = 17'h0E000;
    localparam logic [16:0] c_R1_END   = 17'h12000;
    localparam logic [16:0] c_R2_END   = 17'h16000;
    localparam logic [16:0] c_R3_END   = 17'h16800;
    localparam int          c_HOLD_CYC = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    typedef logic [1:0] region_idx_t;

    function automatic logic [3:0] region_onehot(input region_idx_t idx);
        region_onehot = 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_download_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rom_download_ctrl_if
//  Brief    : HPS ioctl download bus in, region-relative ROM write bus out.
//  Revision : 1.0  initial release
// ============================================================================
interface rom_download_ctrl_if #(
    parameter int AW = 17
);
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [3:0]    rom_we;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  rom_we, rom_addr, rom_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output rom_we, rom_addr, rom_data
    );
endinterface
`default_nettype wire

// File: rtl/rom_region_decode.sv
`default_nettype none
// ============================================================================
//  Module   : rom_region_decode
//  Brief    : Maps a download byte address to a one-hot region and offset.
//  Revision : 1.0  initial release
// ============================================================================
module rom_region_decode
    import rom_dl_pkg::*;
#(
    parameter int            AW     = c_AW,
    parameter logic [AW-1:0] R0_END = AW'(c_R0_END),
    parameter logic [AW-1:0] R1_END = AW'(c_R1_END),
    parameter logic [AW-1:0] R2_END = AW'(c_R2_END),
    parameter logic [AW-1:0] R3_END = AW'(c_R3_END)
) (
    input  wire  [AW-1:0] i_addr,
    output logic [3:0]    o_sel,
    output logic [AW-1:0] o_rel_addr,
    output logic          o_out_of_range
);

    region_idx_t   w_idx;
    logic [AW-1:0] w_base;

    // Ends are exclusive, so an address equal to an end belongs to the next region.
    always_comb begin
        w_idx          = 2'd0;
        w_base         = '0;
        o_out_of_range = 1'b0;
        if (i_addr < R0_END) begin
            w_idx  = 2'd0;
            w_base = '0;
        end else if (i_addr < R1_END) begin
            w_idx  = 2'd1;
            w_base = R0_END;
        end else if (i_addr < R2_END) begin
            w_idx  = 2'd2;
            w_base = R1_END;
        end else if (i_addr < R3_END) begin
            w_idx  = 2'd3;
            w_base = R2_END;
        end else begin
            o_out_of_range = 1'b1;
        end
        o_rel_addr = i_addr - w_base;
        o_sel      = o_out_of_range ? 4'b0000 : region_onehot(w_idx);
    end

endmodule
`default_nettype wire

// File: rtl/rom_download_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rom_download_ctrl
//  Brief    : Sequences HPS ROM download into four regions and owns core reset.
//  Revision : 1.0  initial release
// ============================================================================
module rom_download_ctrl
    import rom_dl_pkg::*;
#(
    parameter int            AW       = c_AW,
    parameter logic [AW-1:0] R0_END   = AW'(c_R0_END),
    parameter logic [AW-1:0] R1_END   = AW'(c_R1_END),
    parameter logic [AW-1:0] R2_END   = AW'(c_R2_END),
    parameter logic [AW-1:0] R3_END   = AW'(c_R3_END),
    parameter int            HOLD_CYC = c_HOLD_CYC
) (
    input  wire           clk_sys,
    input  wire           reset,
    rom_download_ctrl_if.slave bus,
    input  wire           ext_reset,
    output logic          core_reset,
    output logic          load_done,
    output logic          load_error,
    output logic [AW:0]   byte_count
);

    localparam int          c_HCW      = $clog2(HOLD_CYC + 1);
    localparam logic [AW:0] c_IMG_SIZE = {1'b0, R3_END};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_dl_q;
    logic [c_HCW-1:0] r_hold_cnt;

    logic [3:0]       r_rom_we;
    logic [AW-1:0]    r_rom_addr;
    logic [7:0]       r_rom_data;
    logic             r_core_reset;
    logic             r_load_done;
    logic             r_load_error;
    logic [AW:0]      r_byte_count;

    logic             w_dl_fall;
    logic             w_hold_done;
    logic             w_enter_load;
    logic             w_load_end;
    logic             w_accept;
    logic             w_overrun;
    logic             w_core_reset_d;
    logic             w_size_bad;

    logic [3:0]       w_sel;
    logic [AW-1:0]    w_rel_addr;
    logic             w_oor;

    rom_region_decode #(
        .AW     (AW),
        .R0_END (R0_END),
        .R1_END (R1_END),
        .R2_END (R2_END),
        .R3_END (R3_END)
    ) u_decode (
        .i_addr         (bus.ioctl_addr),
        .o_sel          (w_sel),
        .o_rel_addr     (w_rel_addr),
        .o_out_of_range (w_oor)
    );

    assign w_dl_fall   = r_dl_q & ~bus.ioctl_download;
    assign w_hold_done = (r_hold_cnt == c_HCW'(HOLD_CYC - 1));

    // State register and hold counter
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_HOLD && w_state_nxt == ST_HOLD)
                r_hold_cnt <= r_hold_cnt + c_HCW'(1);
            else
                r_hold_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.ioctl_download) w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_dl_fall)          w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (bus.ioctl_download)
                    w_state_nxt = ST_LOAD;
                else if (w_hold_done)
                    w_state_nxt = r_load_done ? ST_RUN : ST_IDLE;
            end
            ST_RUN:  if (bus.ioctl_download) w_state_nxt = ST_LOAD;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/control decode; the cycle the falling edge is seen drops any strobe.
    always_comb begin
        w_enter_load   = (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);
        w_load_end     = (r_state == ST_LOAD) && w_dl_fall;
        w_accept       = (r_state == ST_LOAD) && !w_dl_fall && bus.ioctl_wr && !w_oor;
        w_overrun      = (r_state == ST_LOAD) && !w_dl_fall && bus.ioctl_wr &&  w_oor;
        w_core_reset_d = (r_state == ST_RUN) ? ext_reset : 1'b1;
        w_size_bad     = (r_byte_count != c_IMG_SIZE);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dl_q       <= 1'b0;
            r_rom_we     <= 4'b0000;
            r_rom_addr   <= '0;
            r_rom_data   <= 8'h00;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_dl_q       <= bus.ioctl_download;
            r_core_reset <= w_core_reset_d;
            r_rom_we     <= 4'b0000;
            if (w_accept) begin
                r_rom_we   <= w_sel;
                r_rom_addr <= w_rel_addr;
                r_rom_data <= bus.ioctl_dout;
                if (r_byte_count != '1)
                    r_byte_count <= r_byte_count + (AW+1)'(1);
            end
            if (w_overrun)
                r_load_error <= 1'b1;
            if (w_enter_load) begin
                r_byte_count <= '0;
                r_load_error <= 1'b0;
                r_load_done  <= 1'b0;
            end
            if (w_load_end) begin
                r_load_error <= r_load_error | w_size_bad;
                r_load_done  <= ~(r_load_error | w_size_bad);
            end
        end
    end

    assign bus.rom_we   = r_rom_we;
    assign bus.rom_addr = r_rom_addr;
    assign bus.rom_data = r_rom_data;
    assign core_reset   = r_core_reset;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;
    assign byte_count   = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_rom_download_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_download_ctrl
//  Brief    : Directed bench for rom_download_ctrl on a scaled-down region map.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rom_download_ctrl;
    import rom_dl_pkg::*;

    localparam int c_HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ext_reset;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [17:0] byte_count;

    logic [16:0] dec_addr;
    logic [3:0]  dec_sel;
    logic [16:0] dec_rel;
    logic        dec_oor;

    int n_checks = 0;
    int n_fail   = 0;
    int reg_cnt[4];
    logic cr_low_seen;

    always #5 clk_sys = ~clk_sys;

    rom_download_ctrl_if #(.AW(17)) bus ();

    rom_download_ctrl #(
        .AW       (17),
        .R0_END   (17'h000E0),
        .R1_END   (17'h00120),
        .R2_END   (17'h00160),
        .R3_END   (17'h00168),
        .HOLD_CYC (c_HOLD)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bus        (bus),
        .ext_reset  (ext_reset),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .byte_count (byte_count)
    );

    // Default (full-size) region map checked directly on the decoder.
    rom_region_decode u_dec (
        .i_addr         (dec_addr),
        .o_sel          (dec_sel),
        .o_rel_addr     (dec_rel),
        .o_out_of_range (dec_oor)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
        if (!core_reset) cr_low_seen = 1'b1;
    endtask

    task automatic send_range(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 17'(a);
            bus.ioctl_dout = 8'(a) ^ 8'h5A;
            tick(1);
            for (int r = 0; r < 4; r++) if (bus.rom_we[r]) reg_cnt[r]++;
            if (a == 'hDF) begin
                chk("we_0DF", 32'(bus.rom_we), 32'h1);
                chk("addr_0DF", 32'(bus.rom_addr), 32'hDF);
                chk("data_0DF", 32'(bus.rom_data), 32'h85);
            end
            if (a == 'hE0) begin
                chk("we_0E0", 32'(bus.rom_we), 32'h2);
                chk("addr_0E0", 32'(bus.rom_addr), 32'h0);
                chk("data_0E0", 32'(bus.rom_data), 32'hBA);
            end
            if (a == 'h120) begin
                chk("we_120", 32'(bus.rom_we), 32'h4);
                chk("addr_120", 32'(bus.rom_addr), 32'h0);
            end
            if (a == 'h167) begin
                chk("we_167", 32'(bus.rom_we), 32'h8);
                chk("addr_167", 32'(bus.rom_addr), 32'h7);
                chk("data_167", 32'(bus.rom_data), 32'h3D);
            end
        end
        bus.ioctl_wr = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        ext_reset          = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = 8'h00;
        cr_low_seen        = 1'b0;
        for (int r = 0; r < 4; r++) reg_cnt[r] = 0;

        // Decoder on the default map
        dec_addr = 17'h0DFFF; #1;
        chk("dec_sel_0DFFF", 32'(dec_sel), 32'h1);
        chk("dec_rel_0DFFF", 32'(dec_rel), 32'h0DFFF);
        dec_addr = 17'h0E000; #1;
        chk("dec_sel_0E000", 32'(dec_sel), 32'h2);
        chk("dec_rel_0E000", 32'(dec_rel), 32'h0);
        dec_addr = 17'h167FF; #1;
        chk("dec_sel_167FF", 32'(dec_sel), 32'h8);
        chk("dec_rel_167FF", 32'(dec_rel), 32'h7FF);
        dec_addr = 17'h16800; #1;
        chk("dec_sel_16800", 32'(dec_sel), 32'h0);
        chk("dec_oor_16800", 32'(dec_oor), 32'h1);

        // Reset state and idle with no download
        tick(2);
        chk("rst_core_reset", 32'(core_reset), 32'h1);
        chk("rst_we", 32'(bus.rom_we), 32'h0);
        chk("rst_addr", 32'(bus.rom_addr), 32'h0);
        chk("rst_data", 32'(bus.rom_data), 32'h0);
        chk("rst_done", 32'(load_done), 32'h0);
        chk("rst_err", 32'(load_error), 32'h0);
        chk("rst_bc", 32'(byte_count), 32'h0);
        reset = 1'b0;
        tick(20);
        chk("idle_core_reset_low_seen", 32'(cr_low_seen), 32'h0);
        chk("idle_done", 32'(load_done), 32'h0);
        chk("idle_state", 32'(dut.r_state), 32'(ST_IDLE));

        // Full image, back-to-back writes
        bus.ioctl_download = 1'b1;
        tick(1);
        send_range(0, 'h167);
        bus.ioctl_download = 1'b0;
        tick(1);
        chk("full_we_after", 32'(bus.rom_we), 32'h0);
        chk("full_bc", 32'(byte_count), 32'h168);
        chk("full_done", 32'(load_done), 32'h1);
        chk("full_err", 32'(load_error), 32'h0);
        chk("cnt_r0", 32'(reg_cnt[0]), 32'hE0);
        chk("cnt_r1", 32'(reg_cnt[1]), 32'h40);
        chk("cnt_r2", 32'(reg_cnt[2]), 32'h40);
        chk("cnt_r3", 32'(reg_cnt[3]), 32'h08);
        tick(c_HOLD);
        chk("hold_core_reset_still_high", 32'(core_reset), 32'h1);
        chk("hold_core_reset_low_seen", 32'(cr_low_seen), 32'h0);
        tick(1);
        chk("run_core_reset_low", 32'(core_reset), 32'h0);
        chk("run_state", 32'(dut.r_state), 32'(ST_RUN));

        // ext_reset pulse in RUN, strobes with download low ignored
        ext_reset      = 1'b1;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 17'h00010;
        chk("ext_delay", 32'(core_reset), 32'h0);
        tick(1);
        chk("ext_c1", 32'(core_reset), 32'h1);
        chk("run_wr_ignored", 32'(bus.rom_we), 32'h0);
        tick(1);
        chk("ext_c2", 32'(core_reset), 32'h1);
        tick(1);
        chk("ext_c3", 32'(core_reset), 32'h1);
        ext_reset    = 1'b0;
        bus.ioctl_wr = 1'b0;
        tick(1);
        chk("ext_release", 32'(core_reset), 32'h0);
        chk("run_bc_kept", 32'(byte_count), 32'h168);
        chk("run_done_kept", 32'(load_done), 32'h1);

        // Redownload from RUN as a short image
        bus.ioctl_download = 1'b1;
        tick(1);
        chk("redl_run_state", 32'(dut.r_state), 32'(ST_LOAD));
        chk("redl_run_bc", 32'(byte_count), 32'h0);
        chk("redl_run_done", 32'(load_done), 32'h0);
        tick(1);
        chk("redl_run_core_reset", 32'(core_reset), 32'h1);
        cr_low_seen = 1'b0;
        send_range(0, 'h3F);
        bus.ioctl_download = 1'b0;
        tick(1);
        chk("short_bc", 32'(byte_count), 32'h40);
        chk("short_err", 32'(load_error), 32'h1);
        chk("short_done", 32'(load_done), 32'h0);
        tick(c_HOLD + 14);
        chk("short_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("short_core_reset_low_seen", 32'(cr_low_seen), 32'h0);
        chk("short_done_idle", 32'(load_done), 32'h0);

        // Out-of-range writes inside an otherwise full image
        bus.ioctl_download = 1'b1;
        tick(1);
        send_range(0, 'h50);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 17'h00168;
        tick(1);
        chk("oor_end_we", 32'(bus.rom_we), 32'h0);
        chk("oor_end_err", 32'(load_error), 32'h1);
        chk("oor_end_bc", 32'(byte_count), 32'h51);
        bus.ioctl_addr = 17'h1FFFF;
        tick(1);
        chk("oor_max_we", 32'(bus.rom_we), 32'h0);
        chk("oor_max_bc", 32'(byte_count), 32'h51);
        send_range('h51, 'h167);
        bus.ioctl_download = 1'b0;
        tick(1);
        chk("oor_bc", 32'(byte_count), 32'h168);
        chk("oor_err", 32'(load_error), 32'h1);
        chk("oor_done", 32'(load_done), 32'h0);
        tick(c_HOLD + 2);
        chk("oor_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("oor_core_reset", 32'(core_reset), 32'h1);

        // Redownload during HOLD
        bus.ioctl_download = 1'b1;
        tick(1);
        send_range(0, 'h167);
        bus.ioctl_download = 1'b0;
        tick(1);
        chk("hold_entry_done", 32'(load_done), 32'h1);
        tick(5);
        chk("hold_cnt_5", 32'(dut.r_hold_cnt), 32'h5);
        bus.ioctl_download = 1'b1;
        tick(1);
        chk("redl_hold_state", 32'(dut.r_state), 32'(ST_LOAD));
        chk("redl_hold_cnt", 32'(dut.r_hold_cnt), 32'h0);
        chk("redl_hold_done", 32'(load_done), 32'h0);
        chk("redl_hold_bc", 32'(byte_count), 32'h0);
        send_range(0, 'h20);
        chk("redl_hold_core_reset_low_seen", 32'(cr_low_seen), 32'h0);
        chk("mid_bc", 32'(byte_count), 32'h21);

        // Asynchronous reset in the middle of LOAD
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 17'h00030;
        bus.ioctl_dout = 8'hC3;
        tick(1);
        chk("mid_we", 32'(bus.rom_we), 32'h1);
        #3 reset = 1'b1;
        #1;
        chk("arst_we", 32'(bus.rom_we), 32'h0);
        chk("arst_addr", 32'(bus.rom_addr), 32'h0);
        chk("arst_data", 32'(bus.rom_data), 32'h0);
        chk("arst_bc", 32'(byte_count), 32'h0);
        chk("arst_core_reset", 32'(core_reset), 32'h1);
        chk("arst_done", 32'(load_done), 32'h0);
        chk("arst_err", 32'(load_error), 32'h0);
        chk("arst_state", 32'(dut.r_state), 32'(ST_IDLE));
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        tick(3);
        chk("post_arst_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("post_arst_core_reset", 32'(core_reset), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
